uart_alu_seq: RTL and testbench



---
 rtl/uart_alu_pkg.sv | 27 ++
 rtl/uart_byte_fifo.sv | 70 +++++++
 rtl/uart_alu_seq.sv | 177 +++++++++++++++++
 tb/tb_uart_alu_seq.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_pkg.sv
// Shared opcodes, FSM states and error codes for the UART ALU packet sequencer.
package uart_alu_pkg;

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hAD;
    localparam logic [7:0] OP_XOR  = 8'h58;

    localparam int HDR_BYTES = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_HDR2,
        S_HDR3,
        S_PAYLOAD,
        S_RESP,
        S_DRAIN
    } seq_state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_FORMAT   = 2'd1,
        ERR_OVERFLOW = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with a registered head; head is valid the cycle after the first push.
// Push when full without a same-cycle pop is ignored (caller flags overflow); pop when empty is ignored.
module uart_byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_vld,
    input  logic [7:0] push_dat,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output logic [7:0] head_dat
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CNT  = (AW + 1)'(1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same edge, so push-while-full with pop is legal.
    assign do_push = push_vld && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            head_dat <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Head register tracks the entry that will be at rd_ptr after this edge.
            if (do_pop) begin
                if (count > ONE_CNT) begin
                    head_dat <= mem[rd_ptr + 1'b1];
                end else if (do_push) begin
                    head_dat <= push_dat;
                end
            end else if (do_push && empty) begin
                head_dat <= push_dat;
            end
        end
    end

endmodule

// File: rtl/uart_alu_seq.sv
// Packet sequencer: parses RX command packets (echo/add/xor) and queues response bytes for UART TX.
// Echo bytes reach the FIFO one cycle after their strobe; RX has no backpressure, TX drains on valid&ready.
module uart_alu_seq #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    import uart_alu_pkg::*;

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] HDR_LEN = 16'(HDR_BYTES);

    seq_state_e    state;
    logic [7:0]    opcode;
    logic [7:0]    len_lo;
    logic [15:0]   remaining;
    logic [23:0]   word_sr;
    logic [31:0]   acc;
    logic [1:0]    byte_idx;
    logic [TW-1:0] idle_cnt;
    logic          push_vld;
    logic [7:0]    push_dat;

    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;
    logic          overflow;
    logic [15:0]   len;
    logic [31:0]   word_next;
    logic [31:0]   acc_next;
    logic          known_op;
    logic          addxor_bad;
    logic          timeout;

    assign len        = {rx_data_i, len_lo};
    assign word_next  = {rx_data_i, word_sr};
    assign acc_next   = (opcode == OP_ADD) ? (acc + word_next) : (acc ^ word_next);
    assign known_op   = (opcode == OP_ECHO) || (opcode == OP_ADD) || (opcode == OP_XOR);
    // (len - 4) % 4 == len % 4, so the low two bits decide word alignment.
    assign addxor_bad = (opcode != OP_ECHO) && ((len < 16'd12) || (len[1:0] != 2'b00));

    assign tx_valid_o = !fifo_empty;
    assign pop        = tx_valid_o && tx_ready_i;
    assign overflow   = push_vld && fifo_full && !pop;
    assign timeout    = (state != S_IDLE) && !rx_valid_i && (idle_cnt == IDLE_LAST);
    assign busy_o     = (state != S_IDLE) || push_vld || !fifo_empty;

    uart_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_i),
        .push_vld (push_vld),
        .push_dat (push_dat),
        .pop      (pop),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .head_dat (tx_data_o)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= S_IDLE;
            opcode     <= '0;
            len_lo     <= '0;
            remaining  <= '0;
            word_sr    <= '0;
            acc        <= '0;
            byte_idx   <= '0;
            idle_cnt   <= '0;
            push_vld   <= 1'b0;
            push_dat   <= '0;
            err_o      <= 1'b0;
            err_code_o <= ERR_NONE;
        end else begin
            push_vld <= 1'b0;
            err_o    <= overflow;
            if (overflow) begin
                err_code_o <= ERR_OVERFLOW;
            end

            if (state == S_IDLE || rx_valid_i) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout) begin
                state      <= S_IDLE;
                acc        <= '0;
                err_o      <= 1'b1;
                err_code_o <= ERR_TIMEOUT;
            end else begin
                case (state)
                    S_IDLE: if (rx_valid_i) begin
                        opcode <= rx_data_i;
                        state  <= S_HDR1;
                    end
                    S_HDR1: if (rx_valid_i) begin
                        state <= S_HDR2;
                    end
                    S_HDR2: if (rx_valid_i) begin
                        len_lo <= rx_data_i;
                        state  <= S_HDR3;
                    end
                    S_HDR3: if (rx_valid_i) begin
                        remaining <= len - HDR_LEN;
                        byte_idx  <= '0;
                        acc       <= '0;
                        if (!known_op || (len < HDR_LEN) || addxor_bad) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_FORMAT;
                            // Only drain when there is payload to swallow.
                            state      <= (len > HDR_LEN) ? S_DRAIN : S_IDLE;
                        end else if (len == HDR_LEN) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                    S_PAYLOAD: if (rx_valid_i) begin
                        remaining <= remaining - 1'b1;
                        if (opcode == OP_ECHO) begin
                            push_vld <= 1'b1;
                            push_dat <= rx_data_i;
                            if (remaining == 16'd1) begin
                                state <= S_IDLE;
                            end
                        end else begin
                            word_sr  <= word_next[31:8];
                            byte_idx <= byte_idx + 1'b1;
                            if (byte_idx == 2'd3) begin
                                acc <= acc_next;
                            end
                            // byte_idx wraps back to 0 here, ready to index RESP bytes.
                            if (remaining == 16'd1) begin
                                state <= S_RESP;
                            end
                        end
                    end
                    S_RESP: begin
                        push_vld <= 1'b1;
                        push_dat <= acc[{byte_idx, 3'b000} +: 8];
                        byte_idx <= byte_idx + 1'b1;
                        if (byte_idx == 2'd3) begin
                            state <= S_IDLE;
                        end
                        if (rx_valid_i) begin
                            err_o      <= 1'b1;
                            err_code_o <= ERR_TIMEOUT;
                        end
                    end
                    S_DRAIN: if (rx_valid_i) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == 16'd1) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_alu_seq.sv
// Scoreboard bench for uart_alu_seq: a packet-level reference model predicts TX bytes and error codes.
module tb_uart_alu_seq;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;

    typedef logic [7:0] bq_t [$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       err;
    logic [1:0] err_code;

    int vectors     = 0;
    int miscompares = 0;
    int ready_mode  = 0;

    logic [7:0] exp_tx  [$];
    logic [1:0] exp_err [$];

    always #5 clk = ~clk;

    uart_alu_seq #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .tx_ready_i (tx_ready),
        .busy_o     (busy),
        .err_o      (err),
        .err_code_o (err_code)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Changes just after the rising edge so the negedge monitor sees the value the next edge uses.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tx_ready = (ready_mode == 1) ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    logic       prev_stall = 1'b0;
    logic [7:0] prev_dat   = 8'h00;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && tx_valid) begin
                check("tx_stable", tx_data, prev_dat);
            end
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    fail_now($sformatf("tx_extra byte %02h", tx_data));
                end else begin
                    check("tx_byte", tx_data, exp_tx.pop_front());
                end
            end
            if (err) begin
                if (exp_err.size() == 0) begin
                    fail_now($sformatf("err_extra code %0d", err_code));
                end else begin
                    check("err_code", err_code, exp_err.pop_front());
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_dat   = tx_data;
        end
    end

    // Packet-level reference: what a complete packet should produce.
    task automatic model_pkt(input bq_t p);
        logic [7:0]  op;
        int          len;
        logic [31:0] acc;
        logic [31:0] w;
        op  = p[0];
        len = int'({p[3], p[2]});
        acc = 32'h0;
        if (!(op == 8'hEC || op == 8'hAD || op == 8'h58) || len < 4 ||
            (op != 8'hEC && (len < 12 || (len - 4) % 4 != 0))) begin
            exp_err.push_back(2'd1);
            return;
        end
        if (op == 8'hEC) begin
            for (int i = 4; i < len; i++) exp_tx.push_back(p[i]);
        end else begin
            for (int k = 4; k < len; k += 4) begin
                w   = {p[k+3], p[k+2], p[k+1], p[k]};
                acc = (op == 8'hAD) ? acc + w : acc ^ w;
            end
            for (int b = 0; b < 4; b++) exp_tx.push_back(acc[8*b +: 8]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(4, 7)) @(negedge clk);
    endtask

    task automatic send_pkt(input bq_t p, input bit use_model);
        if (use_model) model_pkt(p);
        foreach (p[i]) send_byte(p[i]);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_err.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail_now({name, "_drain_timeout"});
        repeat (3) @(negedge clk);
        check({name, "_busy_idle"}, busy, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t         p;
        int          kind;
        int          len;
        logic [7:0]  op;

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_code", err_code, 2'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        p = '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h41, 8'h42, 8'h43};
        send_pkt(p, 1'b1);
        wait_drain("echo");

        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        send_pkt(p, 1'b1);
        wait_drain("add_wrap");

        p = '{8'h58, 8'h00, 8'h10, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
              8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
        send_pkt(p, 1'b1);
        wait_drain("xor");

        p = '{8'h99, 8'h00, 8'h06, 8'h00, 8'h11, 8'h22};
        send_pkt(p, 1'b1);
        p = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_pkt(p, 1'b1);
        wait_drain("bad_opcode");

        p = '{8'hAD, 8'h00, 8'h0E, 8'h00};
        for (int i = 0; i < 10; i++) p.push_back(8'($urandom));
        send_pkt(p, 1'b1);
        wait_drain("add_bad_len");

        // Backpressure: ten echo bytes into an eight-entry FIFO with TX stalled.
        ready_mode = 1;
        repeat (3) @(negedge clk);
        p = '{8'hEC, 8'h00, 8'h0E, 8'h00};
        for (int i = 0; i < 10; i++) p.push_back(8'h60 + 8'(i));
        for (int i = 0; i < DEPTH; i++) exp_tx.push_back(p[4+i]);
        exp_err.push_back(2'd2);
        exp_err.push_back(2'd2);
        send_pkt(p, 1'b0);
        repeat (4) @(negedge clk);
        check("bp_valid", tx_valid, 1'b1);
        check("bp_head", tx_data, 8'h60);
        check("bp_code", err_code, 2'd2);
        ready_mode = 0;
        wait_drain("backpressure");

        // Truncated ADD packet, then silence until the timeout fires.
        exp_err.push_back(2'd3);
        p = '{8'hAD, 8'h00, 8'h0C, 8'h00, 8'h01};
        send_pkt(p, 1'b0);
        wait_drain("timeout");
        check("timeout_code", err_code, 2'd3);

        // Reset in the middle of an echo payload with bytes parked in the FIFO.
        ready_mode = 1;
        repeat (3) @(negedge clk);
        p = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
        send_pkt(p, 1'b0);
        @(negedge clk);
        check("pre_rst_valid", tx_valid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 1'b0);
        check("mid_rst_tx_data", tx_data, 8'h00);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_err_code", err_code, 2'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        ready_mode = 0;
        p = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'hA5, 8'h5A};
        send_pkt(p, 1'b1);
        wait_drain("post_reset_echo");

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1: begin op = 8'hEC; len = $urandom_range(4, 12); end
                2:    begin op = 8'hAD; len = 4 + 4 * $urandom_range(2, 4); end
                3:    begin op = 8'h58; len = 4 + 4 * $urandom_range(2, 4); end
                4: begin
                    do op = 8'($urandom); while (op == 8'hEC || op == 8'hAD || op == 8'h58);
                    len = $urandom_range(0, 9);
                end
                default: begin
                    op  = ($urandom_range(0, 1) != 0) ? 8'hAD : 8'h58;
                    len = $urandom_range(4, 14);
                end
            endcase
            p = '{op, 8'($urandom), 8'(len), 8'(len >> 8)};
            for (int i = 4; i < len; i++) p.push_back(8'($urandom));
            send_pkt(p, 1'b1);
        end
        wait_drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
